// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the PC sequencer and its controller.
// The master side drives the requests and the slave side (the sequencer) returns PC state.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              run;
  logic              step;
  logic              halt;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] pc;
  logic              fetch_stb;
  logic              wrap;
  logic [CNT_W-1:0]  fetch_cnt;
  logic              fault;

  modport master (
    output run, step, halt, load_en, load_addr,
    input  pc, fetch_stb, wrap, fetch_cnt, fault
  );

  modport slave (
    input  run, step, halt, load_en, load_addr,
    output pc, fetch_stb, wrap, fetch_cnt, fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: free-run tick or single-step advance, jump loads, halt.
// Optional PC_BOUNDS_CHECK_EN rejects out-of-range/misaligned loads and raises a sticky fault.
module pc_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int MEM_SIZE = 64,
  parameter int STRIDE   = 4,
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 16
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  pc_sequencer_if.slave  bus
);

  localparam int                TW         = $clog2(TICK_DIV);
  localparam logic [TW-1:0]     TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [ADDR_W:0]   MEM_LIM    = (ADDR_W+1)'(MEM_SIZE);
  localparam logic [ADDR_W:0]   STRIDE_X   = (ADDR_W+1)'(STRIDE);
  localparam logic [ADDR_W-1:0] ALIGN_BITS = ADDR_W'(STRIDE - 1);

  logic [TW-1:0]     tick_q, tick_d;
  logic              step_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              stb_q, stb_d;
  logic              wrap_q, wrap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick, step_rise, adv;
  logic [ADDR_W:0]   nxt;
`ifdef PC_BOUNDS_CHECK_EN
  logic              fault_q, fault_d;
  logic              load_bad;
`else
  logic [ADDR_W-1:0] load_aligned;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    tick      = bus.run && (tick_q == TICK_LAST);
    step_rise = bus.step & ~step_q;
    adv       = ~bus.halt & ((bus.run & tick) | (~bus.run & step_rise));
    nxt       = {1'b0, pc_q} + STRIDE_X;

    if (!bus.run)      tick_d = '0;
    else if (bus.halt) tick_d = tick_q;
    else if (tick)     tick_d = '0;
    else               tick_d = tick_q + 1'b1;

    pc_d   = pc_q;
    stb_d  = 1'b0;
    wrap_d = 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
    fault_d  = fault_q;
    load_bad = ({1'b0, bus.load_addr} >= MEM_LIM) || ((bus.load_addr & ALIGN_BITS) != '0);
`else
    load_aligned = bus.load_addr & ~ALIGN_BITS;
`endif

    // A load always takes the cycle, so a coincident advance is dropped even if the load is rejected.
    if (bus.load_en) begin
`ifdef PC_BOUNDS_CHECK_EN
      if (load_bad) begin
        fault_d = 1'b1;
      end else begin
        pc_d  = bus.load_addr;
        stb_d = 1'b1;
      end
`else
      pc_d  = ({1'b0, load_aligned} >= MEM_LIM) ? '0 : load_aligned;
      stb_d = 1'b1;
`endif
    end else if (adv) begin
      stb_d = 1'b1;
      if (nxt >= MEM_LIM) begin
        pc_d   = '0;
        wrap_d = 1'b1;
      end else begin
        pc_d = nxt[ADDR_W-1:0];
      end
    end

    // Counting alongside the strobe keeps fetch_cnt inclusive of the pulse currently on the output.
    cnt_d = cnt_q + CNT_W'(stb_d);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      tick_q  <= '0;
      step_q  <= 1'b0;
      pc_q    <= '0;
      stb_q   <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef PC_BOUNDS_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      tick_q  <= tick_d;
      step_q  <= bus.step;
      pc_q    <= pc_d;
      stb_q   <= stb_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
`ifdef PC_BOUNDS_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign bus.pc        = pc_q;
  assign bus.fetch_stb = stb_q;
  assign bus.wrap      = wrap_q;
  assign bus.fetch_cnt = cnt_q;
`ifdef PC_BOUNDS_CHECK_EN
  assign bus.fault     = fault_q;
`else
  assign bus.fault     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random stimulus,
// every cycle compared against a cycle-level behavioural model of the sequencer rules.
module tb_pc_sequencer;

  localparam int TICK_DIV = 4;
  localparam int MEM_SIZE = 64;
  localparam int STRIDE   = 4;
  localparam int ADDR_W   = 32;
  localparam int CNT_W    = 16;

  logic sys_clk = 1'b0;
  logic sys_rst;
  int   tests = 0;
  int   fails = 0;

  pc_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  pc_sequencer #(
    .TICK_DIV(TICK_DIV), .MEM_SIZE(MEM_SIZE), .STRIDE(STRIDE),
    .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference state: PC value, fetch total, sticky fault, run-cycles-since-last-tick, step history.
  int m_pc, m_cnt, m_div;
  bit m_stb, m_wrap, m_fault, m_step_prev;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_div = 0;
    m_stb = 0; m_wrap = 0; m_fault = 0; m_step_prev = 0;
  endtask

  task automatic model_edge();
    bit tick_now, rise, adv;
    int a;
    tick_now = bus.run && (m_div == TICK_DIV - 1);
    rise     = bus.step && !m_step_prev;
    adv      = !bus.halt && (bus.run ? tick_now : rise);
    m_stb    = 0;
    m_wrap   = 0;
    a        = int'(bus.load_addr);
    if (bus.load_en) begin
`ifdef PC_BOUNDS_CHECK_EN
      if (a >= MEM_SIZE || (a % STRIDE) != 0) m_fault = 1;
      else begin m_pc = a; m_stb = 1; end
`else
      a     = a - (a % STRIDE);
      m_pc  = (a >= MEM_SIZE) ? 0 : a;
      m_stb = 1;
`endif
    end else if (adv) begin
      m_stb = 1;
      if (m_pc + STRIDE >= MEM_SIZE) begin m_pc = 0; m_wrap = 1; end
      else m_pc = m_pc + STRIDE;
    end
    if (!bus.run)      m_div = 0;
    else if (!bus.halt) m_div = tick_now ? 0 : m_div + 1;
    if (m_stb) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    m_step_prev = bus.step;
  endtask

  task automatic check_all();
    check("pc",        bus.pc,        m_pc);
    check("fetch_stb", bus.fetch_stb, m_stb);
    check("wrap",      bus.wrap,      m_wrap);
    check("fetch_cnt", bus.fetch_cnt, m_cnt);
    check("fault",     bus.fault,     m_fault);
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      model_edge();
      #1;
      check_all();
    end
  endtask

  initial begin
    sys_rst       = 1'b0;
    bus.run       = 1'b0;
    bus.step      = 1'b0;
    bus.halt      = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    model_reset();
    #12;
    check_all();
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;

    // Free-run from reset: sixteen advances end on the 60 -> 0 wrap.
    bus.run = 1'b1;
    cyc(63);
    check("pre_wrap_pc", bus.pc, 60);
    cyc(1);
    check("wrap_pc", bus.pc, 0);
    check("wrap_pulse", bus.wrap, 1);
    check("wrap_cnt", bus.fetch_cnt, 16);

    // Jump issued in the tick cycle: load wins, counter still restarts.
    for (int i = 0; i < 8 && m_div != TICK_DIV - 1; i++) cyc(1);
    check("jump_in_tick", m_div, TICK_DIV - 1);
    bus.load_en = 1'b1; bus.load_addr = 40;
    cyc(1);
    bus.load_en = 1'b0;
    check("jump_pc", bus.pc, 40);
    check("jump_stb", bus.fetch_stb, 1);
    cyc(4);
    check("jump_next", bus.pc, 44);

    // Halt mid-count with a load accepted while halted.
    for (int i = 0; i < 8 && m_div != 2; i++) cyc(1);
    bus.halt = 1'b1;
    cyc(10);
    check("halt_pc", bus.pc, 44);
    bus.load_en = 1'b1; bus.load_addr = 12;
    cyc(1);
    bus.load_en = 1'b0;
    check("halt_load", bus.pc, 12);
    cyc(9);
    bus.halt = 1'b0;
    cyc(1);
    check("halt_resume_wait", bus.pc, 12);
    cyc(1);
    check("halt_resume_adv", bus.pc, 16);

    // Single-step: a held step yields one advance per rising edge.
    bus.run = 1'b0;
    cyc(2);
    bus.step = 1'b1;
    cyc(10);
    check("step_one", bus.pc, 20);
    bus.step = 1'b0;
    cyc(2);
    bus.step = 1'b1;
    cyc(2);
    check("step_two", bus.pc, 24);

    // Out-of-range and misaligned loads.
    bus.load_en = 1'b1; bus.load_addr = 66;
    cyc(1);
`ifdef PC_BOUNDS_CHECK_EN
    check("load66_pc", bus.pc, 24);
    check("load66_fault", bus.fault, 1);
    check("load66_stb", bus.fetch_stb, 0);
`else
    check("load66_pc", bus.pc, 0);
    check("load66_stb", bus.fetch_stb, 1);
`endif
    bus.load_addr = 22;
    cyc(1);
    bus.load_en = 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
    check("load22_pc", bus.pc, 24);
`else
    check("load22_pc", bus.pc, 20);
`endif

    // Async reset with pc=28 and count=2.
    bus.run = 1'b1; bus.load_en = 1'b1; bus.load_addr = 28;
    cyc(1);
    bus.load_en = 1'b0;
    cyc(1);
    check("pre_rst_pc", bus.pc, 28);
    check("pre_rst_div", m_div, 2);
    sys_rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    cyc(3);
    check("post_rst_idle", bus.fetch_stb, 0);
    cyc(1);
    check("post_rst_tick", bus.pc, 4);

    // Random stimulus against the model.
    for (int seg = 0; seg < 12; seg++) begin
      bus.run = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 30; i++) begin
        bus.halt      = ($urandom_range(0, 7) == 0);
        bus.step      = $urandom_range(0, 1) == 1;
        bus.load_en   = ($urandom_range(0, 11) == 0);
        bus.load_addr = ADDR_W'($urandom_range(0, 80));
        cyc(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the demo computer. It sits between the board clock and instruction memory and derives a slow execution tick from `sys_clk`. It steps a byte-addressed PC through a memory of configurable size in either free-run or single-step mode, and supports jump loads and halt. It emits a one-cycle fetch strobe for memory and the display path.

## Interface
- `TICK_DIV`, 50000000: `sys_clk` cycles per run-mode tick; must be ≥ 2.
- `MEM_SIZE`, 64: memory size in bytes; must be a multiple of `STRIDE`.
- `STRIDE`, 4: PC increment in bytes; must be a power of two.
- `ADDR_W`, 32: PC width.
- `CNT_W`, 16: fetch counter width.

- `sys_clk` in 1: single clock.
- `sys_rst` in 1: asynchronous, active-low reset.
- `run` in 1: 1 = free-run on tick, 0 = single-step mode.
- `step` in 1: step request, level, already debounced; its rising edge advances the PC when `run`=0.
- `halt` in 1: freezes advancement.
- `load_en` in 1: jump request, sampled each cycle.
- `load_addr` in ADDR_W: jump target.
- `pc` out ADDR_W: current byte address.
- `fetch_stb` out 1: one-cycle pulse, first cycle a new `pc` is valid.
- `wrap` out 1: one-cycle pulse, coincident with `fetch_stb`, when the PC wrapped to 0.
- `fetch_cnt` out CNT_W: number of `fetch_stb` pulses, modulo 2^CNT_W.
- `fault` out 1: sticky bad-load flag (see Configuration).

## Operation
- **Reset (async, `sys_rst`=0).** `pc`=0, `fetch_stb`=0, `wrap`=0, `fetch_cnt`=0, `fault`=0, tick counter=0, step edge register=0. Outputs take these values immediately.
- **Tick counter.**
  - Counts 0..TICK_DIV-1 while `run`=1 and `halt`=0.
  - `tick` is high in the cycle the count equals TICK_DIV-1; the count returns to 0 on the next edge.
  - Cleared to 0 whenever `run`=0.
  - Holds its value while `halt`=1 and `run`=1.
- **Step edge.** `step_rise` = `step` & ~`step_q`, where `step_q` is `step` registered every cycle.
- **Advance request.** `adv` = ~`halt` & ((`run` & `tick`) | (~`run` & `step_rise`)).
- **Priority.** `load_en` beats `adv`; `halt` does not block loads.
- **Advance.** `nxt` = `pc` + STRIDE, computed at ADDR_W+1 bits.
  - If `nxt` ≥ MEM_SIZE: `pc`←0 and `wrap` pulses.
  - Otherwise `pc`←`nxt`.
- **Load.** Handled per the Configuration section. An accepted load pulses `fetch_stb` with `wrap`=0.
- **Fetch counter.** `fetch_cnt` increments on every `fetch_stb` and wraps silently from all-ones to 0.
- **Mode switch.** Changing `run` mid-count discards the partial count. The first tick after `run`→1 occurs TICK_DIV cycles later.

## Timing
- All state updates on the rising edge of `sys_clk`.
- **Latency:** request cycle N → new `pc` and `fetch_stb`=1 in cycle N+1. `fetch_stb` returns to 0 in N+2 unless another update occurs.
- **Free-run:** `fetch_stb` period is exactly TICK_DIV cycles.
- **Single-step:** one advance per rising edge of `step`; a held-high `step` gives exactly one advance.
- **Simultaneous `load_en` and `adv`:** the load wins, the advance is dropped, and the tick counter still wraps to 0.
- **`halt` asserted in the tick cycle:** no advance occurs.

## Configuration
- **`PC_BOUNDS_CHECK_EN` defined:**
  - A load is rejected if `load_addr` ≥ MEM_SIZE or `load_addr` mod STRIDE ≠ 0.
  - On rejection, `pc` is unchanged, there is no `fetch_stb`, and `fault`←1.
  - `fault` stays set until reset.
  - Valid loads set `pc`←`load_addr`.
- **Not defined:**
  - The low log2(STRIDE) bits of `load_addr` are forced to 0.
  - If the result is ≥ MEM_SIZE, `pc`←0; otherwise `pc`←result.
  - The load always pulses `fetch_stb`.
  - `fault` is tied to 0.

## Test plan
All scenarios use TICK_DIV=4, MEM_SIZE=64, STRIDE=4.
- **Reset then free-run:** `run`=1 → `pc` goes 4,8,…,60,0 with `fetch_stb` every 4 cycles; `wrap`=1 only on the 60→0 update; `fetch_cnt`=16 after that update.
- **Single-step:** `run`=0, `step` held high for 10 cycles, then low, then high → exactly two advances: `pc`=4, then 8.
- **Jump with simultaneous tick:** `load_en`=1, `load_addr`=40 in the tick cycle → `pc`=40 next cycle, one `fetch_stb`, following tick gives `pc`=44.
- **Halt:** `halt`=1 for 20 cycles during run → `pc` constant with no `fetch_stb`; a load to 12 during halt is accepted; after release, next advance comes after the remaining tick count.
- **Bounds, macro defined:** `load_addr`=66 → `pc` unchanged, `fault`=1, no strobe. **Macro undefined:** same load → `pc`=0 with a strobe; `load_addr`=22 → `pc`=20.
- **Async reset mid-count:** `sys_rst`=0 with `pc`=28 and count=2 → all outputs 0 immediately; first tick comes 4 cycles after release.
